// File: rtl/lz77_decode_sequencer.sv
// Feeds buffered LZ77 code words to the decoder datapath and collects the decoded byte stream.
// Each word is held on the decoder inputs for one settle cycle, then for len+1 step cycles.
module lz77_decode_sequencer #(
   parameter int         FIFO_DEPTH = 4,
   parameter int         SEARCH_LEN = 9,
   parameter logic [7:0] END_CHAR   = 8'h24,
   parameter int         CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       in_pos,
   input  logic [2:0]       in_len,
   input  logic [7:0]       in_char,
   output logic [3:0]       code_pos,
   output logic [2:0]       code_len,
   output logic [7:0]       chardata,
   output logic             dec_step,
   input  logic [7:0]       dec_char,
   output logic             out_valid,
   output logic [7:0]       out_char,
   output logic [CNT_W-1:0] out_cnt,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOAD   = 2'd1;
   localparam logic [1:0] S_EMIT   = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [4:0] POS_LIM  = 5'(SEARCH_LEN);

   logic [14:0]      entry_reg [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [1:0]       state_reg, state_next;
   logic [2:0]       remaining_reg, remaining_next;
   logic [3:0]       code_pos_reg;
   logic [2:0]       code_len_reg;
   logic [7:0]       chardata_reg;
   logic             end_accepted_reg;
   logic             err_reg;
   logic             ready_en_reg;
   logic             out_valid_reg;
   logic [7:0]       out_char_reg;
   logic [CNT_W-1:0] out_cnt_reg;

   logic        fifo_empty, fifo_full;
   logic        accept, pos_ok, push, pop, is_term;
   logic [14:0] head;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == FULL_CNT);
   assign is_term    = (chardata_reg == END_CHAR);
   assign head       = entry_reg[rd_ptr_reg];

   // ready_en keeps in_ready low while reset is held and for the cycle it is released
   assign in_ready = ready_en_reg && !fifo_full && !end_accepted_reg && (state_reg != S_DONE);
   assign accept   = in_valid && in_ready;
   assign pos_ok   = ({1'b0, in_pos} < POS_LIM);
   assign push     = accept && pos_ok;

   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      pop            = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            // a terminator contributes only its len copied chars, never the '$' itself
            if (is_term && code_len_reg == 3'd0) begin
               state_next = S_DONE;
            end else if (is_term) begin
               remaining_next = code_len_reg - 3'd1;
               state_next     = S_EMIT;
            end else begin
               state_next = S_EMIT;
            end
         end
         S_EMIT: begin
            if (remaining_reg == 3'd0) begin
               if (is_term) begin
                  state_next = S_DONE;
               end else if (!fifo_empty) begin
                  pop        = 1'b1;
                  state_next = S_LOAD;
               end else begin
                  state_next = S_IDLE;
               end
            end else begin
               remaining_next = remaining_reg - 3'd1;
            end
         end
         S_DONE:  state_next = S_DONE;
         default: state_next = S_IDLE;
      endcase
      if (pop) begin
         remaining_next = head[10:8];
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         entry_reg[wr_ptr_reg] <= {in_pos, in_len, in_char};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg       <= '0;
         rd_ptr_reg       <= '0;
         count_reg        <= '0;
         state_reg        <= S_IDLE;
         remaining_reg    <= '0;
         code_pos_reg     <= '0;
         code_len_reg     <= '0;
         chardata_reg     <= '0;
         end_accepted_reg <= 1'b0;
         err_reg          <= 1'b0;
         ready_en_reg     <= 1'b0;
         out_valid_reg    <= 1'b0;
         out_char_reg     <= '0;
         out_cnt_reg      <= '0;
      end else begin
         ready_en_reg  <= 1'b1;
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         if (pop) begin
            {code_pos_reg, code_len_reg, chardata_reg} <= head;
            rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
         end
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_ONE;
            2'b01:   count_reg <= count_reg - CNT_ONE;
            default: count_reg <= count_reg;
         endcase
         if (accept && in_char == END_CHAR) begin
            end_accepted_reg <= 1'b1;
         end
         if (accept && !pos_ok) begin
            err_reg <= 1'b1;
         end
         out_valid_reg <= dec_step;
         if (dec_step) begin
            out_char_reg <= dec_char;
            if (out_cnt_reg != '1) begin
               out_cnt_reg <= out_cnt_reg + CNT_W'(1);
            end
         end
      end
   end

   assign dec_step  = (state_reg == S_EMIT);
   assign code_pos  = code_pos_reg;
   assign code_len  = code_len_reg;
   assign chardata  = chardata_reg;
   assign out_valid = out_valid_reg;
   assign out_char  = out_char_reg;
   assign out_cnt   = out_cnt_reg;
   assign busy      = (state_reg == S_LOAD) || (state_reg == S_EMIT) || !fifo_empty;
   assign done      = (state_reg == S_DONE);
   assign err       = err_reg;

endmodule

// File: tb/tb_lz77_decode_sequencer.sv
// Directed bench for lz77_decode_sequencer: pushes code words, watches decoder steps
// and the registered output stream, one task per scenario.
module tb_lz77_decode_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_pos = '0;
   logic [2:0]  in_len = '0;
   logic [7:0]  in_char = '0;
   logic [3:0]  code_pos;
   logic [2:0]  code_len;
   logic [7:0]  chardata;
   logic        dec_step;
   logic [7:0]  dec_char;
   logic        out_valid;
   logic [7:0]  out_char;
   logic [15:0] out_cnt;
   logic        busy;
   logic        done;
   logic        err;

   lz77_decode_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pos    (in_pos),
      .in_len    (in_len),
      .in_char   (in_char),
      .code_pos  (code_pos),
      .code_len  (code_len),
      .chardata  (chardata),
      .dec_step  (dec_step),
      .dec_char  (dec_char),
      .out_valid (out_valid),
      .out_char  (out_char),
      .out_cnt   (out_cnt),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   // stand-in decoder: a different char every cycle so latency slips are visible
   assign dec_char = 8'(cyc) ^ 8'h5A;

   int errors = 0;
   int checks = 0;

   logic [14:0] tx_q[$];
   int          acc_cyc[$];
   int          n_acc;
   int          first_low_acc;
   logic [14:0] run_words[$];
   int          run_lens[$];
   int          run_start[$];
   int          n_step, n_out, lat_bad, char_bad, hold_bad;

   function automatic logic [14:0] pack_word(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
      return {p, l, c};
   endfunction

   task automatic clear_stats();
      tx_q.delete(); acc_cyc.delete(); run_words.delete(); run_lens.delete(); run_start.delete();
      n_acc = 0; first_low_acc = -1;
      n_step = 0; n_out = 0; lat_bad = 0; char_bad = 0; hold_bad = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk); #1;
   endtask

   // pushes every word of tx_q in order, holding in_valid until each is taken
   task automatic drive_words();
      foreach (tx_q[k]) begin
         int  guard;
         logic took;
         guard = 0; took = 1'b0;
         in_valid = 1'b1;
         {in_pos, in_len, in_char} = tx_q[k];
         while (!took && guard < 200) begin
            if (!in_ready && first_low_acc < 0) first_low_acc = n_acc;
            took = in_ready;
            @(posedge clk); #1;
            guard++;
         end
         if (!took) begin
            checks++; errors++;
            $display("FAIL push_timeout: word %0d not accepted within %0d cycles", k, guard);
         end else begin
            n_acc++;
            acc_cyc.push_back(cyc);
         end
      end
      in_valid = 1'b0;
   endtask

   // records decoder step runs and output stream statistics for n cycles
   task automatic run_cycles(input int n);
      logic       prev_step;
      logic [7:0] prev_char;
      for (int i = 0; i < n; i++) begin
         prev_step = dec_step;
         prev_char = dec_char;
         @(posedge clk); #1;
         if (out_valid !== prev_step) lat_bad++;
         if (prev_step && out_char !== prev_char) char_bad++;
         if (out_valid) n_out++;
         if (dec_step) begin
            n_step++;
            if (!prev_step) begin
               run_words.push_back({code_pos, code_len, chardata});
               run_lens.push_back(1);
               run_start.push_back(cyc);
            end else begin
               if ({code_pos, code_len, chardata} !== run_words[$]) hold_bad++;
               run_lens[$] = run_lens[$] + 1;
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if ({in_ready, dec_step, out_valid, busy, done, err} !== 6'b0) begin errors++;
         $display("FAIL reset_flags: got %b want 000000", {in_ready, dec_step, out_valid, busy, done, err}); end
      checks++; if ({code_pos, code_len, chardata, out_char, out_cnt} !== 39'b0) begin errors++;
         $display("FAIL reset_data: got %h want 0", {code_pos, code_len, chardata, out_char, out_cnt}); end
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++;
         $display("FAIL reset_ready: got %b want 1", in_ready); end
   endtask

   task automatic test_single_word();
      do_reset(); clear_stats();
      tx_q.push_back(pack_word(4'd2, 3'd3, 8'h41));
      fork drive_words(); run_cycles(12); join
      checks++; if (n_step !== 4) begin errors++; $display("FAIL single_steps: got %0d want 4", n_step); end
      checks++; if (n_out !== 4) begin errors++; $display("FAIL single_outs: got %0d want 4", n_out); end
      checks++; if (lat_bad !== 0 || char_bad !== 0) begin errors++;
         $display("FAIL single_latency: lat_bad %0d char_bad %0d want 0 0", lat_bad, char_bad); end
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL single_hold: got %0d want 0", hold_bad); end
      checks++; if (run_words.size() != 1 || run_words[0] !== pack_word(4'd2, 3'd3, 8'h41)) begin errors++;
         $display("FAIL single_word: runs %0d first %h want 1 %h", run_words.size(),
                  (run_words.size() > 0) ? run_words[0] : 15'h0, pack_word(4'd2, 3'd3, 8'h41)); end
      checks++; if (run_start.size() < 1 || acc_cyc.size() < 1 || run_start[0] - acc_cyc[0] != 2) begin errors++;
         $display("FAIL single_load_gap: got %0d want 2",
                  (run_start.size() > 0 && acc_cyc.size() > 0) ? run_start[0] - acc_cyc[0] : -1); end
      checks++; if (out_cnt !== 16'd4) begin errors++; $display("FAIL single_cnt: got %0d want 4", out_cnt); end
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
         $display("FAIL single_idle: done %b busy %b want 0 0", done, busy); end
   endtask

   task automatic test_terminator();
      do_reset(); clear_stats();
      tx_q.push_back(pack_word(4'd0, 3'd0, 8'h35));
      tx_q.push_back(pack_word(4'd0, 3'd0, 8'h24));
      fork drive_words(); run_cycles(12); join
      checks++; if (n_step !== 1 || n_out !== 1) begin errors++;
         $display("FAIL term_steps: steps %0d outs %0d want 1 1", n_step, n_out); end
      checks++; if (run_words.size() != 1 || run_words[0] !== pack_word(4'd0, 3'd0, 8'h35)) begin errors++;
         $display("FAIL term_word: runs %0d want 1", run_words.size()); end
      checks++; if ({done, in_ready, busy} !== 3'b100) begin errors++;
         $display("FAIL term_done: done/ready/busy %b want 100", {done, in_ready, busy}); end
      checks++; if (out_cnt !== 16'd1) begin errors++; $display("FAIL term_cnt: got %0d want 1", out_cnt); end
   endtask

   task automatic test_term_len();
      do_reset(); clear_stats();
      tx_q.push_back(pack_word(4'd3, 3'd2, 8'h24));
      fork drive_words(); run_cycles(12); join
      checks++; if (n_step !== 2 || n_out !== 2 || lat_bad !== 0 || char_bad !== 0) begin errors++;
         $display("FAIL termlen_steps: steps %0d outs %0d lat %0d char %0d want 2 2 0 0",
                  n_step, n_out, lat_bad, char_bad); end
      checks++; if (run_lens.size() != 1 || run_lens[0] != 2) begin errors++;
         $display("FAIL termlen_run: runs %0d want one run of 2", run_lens.size()); end
      checks++; if ({done, in_ready} !== 2'b10 || out_cnt !== 16'd2) begin errors++;
         $display("FAIL termlen_done: done/ready %b cnt %0d want 10 2", {done, in_ready}, out_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [14:0] exp_w[6];
      int          exp_l[6];
      int          order_bad, gap_bad;
      exp_w[0] = pack_word(4'd1, 3'd7, 8'h61); exp_l[0] = 7;
      exp_w[1] = pack_word(4'd2, 3'd0, 8'h62); exp_l[1] = 0;
      exp_w[2] = pack_word(4'd3, 3'd1, 8'h63); exp_l[2] = 1;
      exp_w[3] = pack_word(4'd4, 3'd2, 8'h64); exp_l[3] = 2;
      exp_w[4] = pack_word(4'd5, 3'd0, 8'h65); exp_l[4] = 0;
      exp_w[5] = pack_word(4'd6, 3'd3, 8'h66); exp_l[5] = 3;
      do_reset(); clear_stats();
      for (int i = 0; i < 6; i++) tx_q.push_back(exp_w[i]);
      fork drive_words(); run_cycles(45); join
      // one word goes straight into LOAD, then four fill the FIFO before ready drops
      checks++; if (first_low_acc !== 5) begin errors++;
         $display("FAIL b2b_full: ready fell after %0d accepts want 5", first_low_acc); end
      checks++; if (n_acc !== 6) begin errors++; $display("FAIL b2b_accepts: got %0d want 6", n_acc); end
      order_bad = 0; gap_bad = 0;
      if (run_words.size() != 6) order_bad = 99;
      else for (int i = 0; i < 6; i++) begin
         if (run_words[i] !== exp_w[i] || run_lens[i] != exp_l[i] + 1) order_bad++;
         if (i < 5 && run_start[i+1] - run_start[i] != exp_l[i] + 2) gap_bad++;
      end
      checks++; if (order_bad !== 0) begin errors++;
         $display("FAIL b2b_order: %0d bad runs of %0d want 0 bad of 6", order_bad, run_words.size()); end
      checks++; if (gap_bad !== 0) begin errors++; $display("FAIL b2b_throughput: %0d bad gaps want 0", gap_bad); end
      checks++; if (lat_bad !== 0 || char_bad !== 0 || hold_bad !== 0) begin errors++;
         $display("FAIL b2b_stream: lat %0d char %0d hold %0d want 0 0 0", lat_bad, char_bad, hold_bad); end
      checks++; if (out_cnt !== 16'd19 || n_out !== 19) begin errors++;
         $display("FAIL b2b_cnt: out_cnt %0d outs %0d want 19 19", out_cnt, n_out); end
   endtask

   task automatic test_illegal();
      do_reset(); clear_stats();
      tx_q.push_back(pack_word(4'd9, 3'd1, 8'h33));
      tx_q.push_back(pack_word(4'd1, 3'd1, 8'h34));
      fork drive_words(); run_cycles(12); join
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_err: got %b want 1", err); end
      checks++; if (run_words.size() != 1 || run_words[0] !== pack_word(4'd1, 3'd1, 8'h34) || run_lens[0] != 2) begin
         errors++; $display("FAIL illegal_drop: runs %0d want one run of word 1,1,34 len 2", run_words.size()); end
      checks++; if (out_cnt !== 16'd2 || n_step !== 2) begin errors++;
         $display("FAIL illegal_cnt: out_cnt %0d steps %0d want 2 2", out_cnt, n_step); end
   endtask

   task automatic test_reset_mid_emit();
      int seen;
      seen = 0;
      do_reset(); clear_stats();
      tx_q.push_back(pack_word(4'd12, 3'd0, 8'h7A));
      tx_q.push_back(pack_word(4'd2, 3'd7, 8'h78));
      tx_q.push_back(pack_word(4'd1, 3'd1, 8'h79));
      tx_q.push_back(pack_word(4'd1, 3'd1, 8'h77));
      fork
         drive_words();
         begin
            for (int i = 0; i < 40 && seen < 3; i++) begin
               @(posedge clk); #1;
               if (dec_step) seen++;
            end
         end
      join
      checks++; if (seen !== 3) begin errors++; $display("FAIL midrst_reach: steps seen %0d want 3", seen); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL midrst_err_before: got %b want 1", err); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if ({dec_step, out_valid, busy, done, err, in_ready} !== 6'b0 || out_cnt !== 16'd0) begin errors++;
         $display("FAIL midrst_clear: step/valid/busy/done/err/ready %b cnt %0d want 000000 0",
                  {dec_step, out_valid, busy, done, err, in_ready}, out_cnt); end
      reset = 1'b0;
      clear_stats();
      run_cycles(10);
      checks++; if (n_step !== 0 || busy !== 1'b0) begin errors++;
         $display("FAIL midrst_fifo_flushed: steps %0d busy %b want 0 0", n_step, busy); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_terminator();
      test_term_len();
      test_back_to_back();
      test_illegal();
      test_reset_mid_emit();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
